// File: rtl/mig_seq_eval.sv
// mig_seq_eval -- programmable majority-inverter-graph evaluator.
//
// Up to MAX_NODES three-input majority nodes with optionally complemented
// fanins are held in configuration registers and evaluated one node per
// cycle over W bit-parallel input patterns. With W = 2^NUM_IN and
// projection vectors on x, one pass yields a full truth table.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cfg_we     configuration write strobe
//   cfg_addr   node slot 0..MAX_NODES-1, or MAX_NODES for the control word
//   cfg_data   node:    {inv_a,sel_a,inv_b,sel_b,inv_c,sel_c}
//              control: {out_inv,len} in the low AW+1 bits
//   cfg_err    one-cycle pulse after a dropped write (busy or bad address)
//   in_valid   x is valid
//   in_ready   engine idle and able to accept x
//   x          input words, x[i*W +: W] = input i
//   out_valid  y is valid, held until taken
//   out_ready  consumer takes y
//   y          result word
//   busy       engine is not idle
module mig_seq_eval #(
  parameter int NUM_IN    = 4,
  parameter int MAX_NODES = 8,
  parameter int W         = 16,
  localparam int NSIG     = 1 + NUM_IN + MAX_NODES,
  localparam int SELW     = $clog2(NSIG),
  localparam int AW       = $clog2(MAX_NODES + 1),
  localparam int CW       = 3 * (SELW + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [CW-1:0]       cfg_data,
  output logic                cfg_err,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_IN*W-1:0] x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        y,
  output logic                busy
);

  localparam int FW = SELW + 1;
  localparam int IW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       node_cfg_q [MAX_NODES];
  logic [CW-1:0]       node_cfg_d [MAX_NODES];
  logic [AW-1:0]       len_q, len_d;
  logic                out_inv_q, out_inv_d;
  logic [NUM_IN*W-1:0] x_q, x_d;
  logic [W-1:0]        node_q [MAX_NODES];
  logic [W-1:0]        node_d [MAX_NODES];
  logic [W-1:0]        y_q, y_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                cfg_err_q, cfg_err_d;

  logic [NSIG*W-1:0]   sig_flat;
  logic [CW-1:0]       cur_cfg;
  logic [W-1:0]        fan_a, fan_b, fan_c, maj_w;
  logic                last_node;
  logic                cfg_hit;
  logic                accept;

  // Select one fanin from the flattened signal table; indices past the end
  // of the table read as constant 0 before the optional inversion.
  function automatic logic [W-1:0] pick_fanin(input logic [NSIG*W-1:0] sigs,
                                               input logic [FW-1:0]     field);
    logic [W-1:0] v;
    v = '0;
    for (int s = 0; s < NSIG; s++) begin
      if (field[SELW-1:0] == SELW'(s)) v = sigs[s*W +: W];
    end
    return v ^ {W{field[FW-1]}};
  endfunction

  // Signal table: const0, the latched inputs, then node results. Node regs
  // are cleared on acceptance, so self and forward references read 0.
  always_comb begin
    sig_flat = '0;
    sig_flat[W +: NUM_IN*W] = x_q;
    for (int k = 0; k < MAX_NODES; k++) begin
      sig_flat[(1+NUM_IN+k)*W +: W] = node_q[k];
    end
  end

  assign cur_cfg   = node_cfg_q[idx_q];
  assign fan_a     = pick_fanin(sig_flat, cur_cfg[3*FW-1 -: FW]);
  assign fan_b     = pick_fanin(sig_flat, cur_cfg[2*FW-1 -: FW]);
  assign fan_c     = pick_fanin(sig_flat, cur_cfg[FW-1:0]);
  assign maj_w     = (fan_a & fan_b) | (fan_a & fan_c) | (fan_b & fan_c);
  assign last_node = (AW'(idx_q) == (len_q - AW'(1)));

  // A config write blocks acceptance in the same cycle, even if it is dropped.
  assign cfg_hit   = cfg_we && (state_q == IDLE) && (cfg_addr <= AW'(MAX_NODES));
  assign in_ready  = (state_q == IDLE) && !cfg_we;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    node_cfg_d = node_cfg_q;
    len_d      = len_q;
    out_inv_d  = out_inv_q;
    x_d        = x_q;
    node_d     = node_q;
    y_d        = y_q;
    idx_d      = idx_q;
    cfg_err_d  = cfg_we && !cfg_hit;

    if (cfg_hit) begin
      for (int k = 0; k < MAX_NODES; k++) begin
        if (cfg_addr == AW'(k)) node_cfg_d[k] = cfg_data;
      end
      if (cfg_addr == AW'(MAX_NODES)) begin
        out_inv_d = cfg_data[AW];
        // Lengths beyond the node count clamp to the full graph.
        len_d = (cfg_data[AW-1:0] > AW'(MAX_NODES)) ? AW'(MAX_NODES)
                                                    : cfg_data[AW-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d   = x;
          idx_d = '0;
          for (int k = 0; k < MAX_NODES; k++) node_d[k] = '0;
          if (len_q == '0) begin
            y_d     = {W{out_inv_q}};
            state_d = DONE;
          end else begin
            state_d = EVAL;
          end
        end
      end
      EVAL: begin
        node_d[idx_q] = maj_w;
        idx_d         = idx_q + IW'(1);
        if (last_node) begin
          y_d     = maj_w ^ {W{out_inv_q}};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      out_inv_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < MAX_NODES; k++) begin
        node_cfg_q[k] <= '0;
        node_q[k]     <= '0;
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      out_inv_q  <= out_inv_d;
      x_q        <= x_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      cfg_err_q  <= cfg_err_d;
      node_cfg_q <= node_cfg_d;
      node_q     <= node_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;
  assign cfg_err   = cfg_err_q;

endmodule
